// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
//   - opcode values decoded by the controller
//   - FSM state encoding (4-bit, exported on the debug 'state' port)
//   - datapath mux / ALU control encodings
//   - ctrl_t: the packed control word produced by mips_mc_ctrl_decode
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// mips_mc_ctrl_decode: purely combinational state -> control-word decoder.
// Ports:
//   state     in  current FSM state
//   mem_ready in  memory handshake; gates ir_write/pc_write in S_FETCH
//   reset     in  forces all write strobes low while asserted
//   ctrl      out decoded control word
// Optional feature macro: MIPS_MC_CTRL_TRAP_EN (drives trap in S_TRAP;
// otherwise trap is tied low).
import mips_mc_pkg::*;

module mips_mc_ctrl_decode (
    input  state_t state,
    input  logic   mem_ready,
    input  logic   reset,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only load in the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_TRAP: begin
`ifdef MIPS_MC_CTRL_TRAP_EN
                ctrl.trap = 1'b1;
`endif
            end
            default: ctrl = '0;
        endcase

        // Reset holds the state in FETCH asynchronously; the strobes must
        // additionally be masked so a ready fetch cannot load IR/PC.
        if (reset) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.mem_write     = 1'b0;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multi-cycle MIPS core.
// Sequences fetch/decode/execute/memory/write-back for lw, sw, R-type,
// beq, addi and j, with a ready-handshaked unified memory port.
// Parameter:
//   MEM_WAIT_MAX  max consecutive mem_ready=0 cycles tolerated (>=1)
// Ports:
//   clk, reset (async, active-high)
//   opcode, zero, mem_ready             inputs
//   pc_write .. pc_source               datapath control outputs
//   state                               debug state (4 bits)
//   trap                                controller halted
// Optional feature macro: MIPS_MC_CTRL_TRAP_EN -- illegal opcodes and
// memory wait timeouts enter S_TRAP. Undefined: illegal opcodes act as a
// NOP and timeouts are ignored.
import mips_mc_pkg::*;

module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       trap
);

    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MEM_WAIT_MAX);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_mem_state;
    ctrl_t             ctrl;

    // zero is consumed in the datapath via pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);

`ifdef MIPS_MC_CTRL_TRAP_EN
    // Counter already saturated and memory still not ready: one wait too many.
    logic timeout;
    assign timeout = !mem_ready && (wait_cnt == WAIT_SAT);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
`ifdef MIPS_MC_CTRL_TRAP_EN
                else if (timeout) state_d = S_TRAP;
`endif
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_CTRL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            // IR is stable here, so opcode still selects lw vs sw
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
`ifdef MIPS_MC_CTRL_TRAP_EN
                else if (timeout) state_d = S_TRAP;
`endif
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
`ifdef MIPS_MC_CTRL_TRAP_EN
                else if (timeout) state_d = S_TRAP;
`endif
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // The only states that loop on themselves are the memory waits and
    // TRAP, so clearing on any state change is exactly "clear on entry".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (in_mem_state && !mem_ready && (wait_cnt != WAIT_SAT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    mips_mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .reset     (reset),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign trap          = ctrl.trap;
    assign state         = state_q;

endmodule
